// File: rtl/fft_bus_pkg.sv
// rtl/fft_bus_pkg.sv - FSM encoding and peripheral address map for the FFT bus loader
package fft_bus_pkg;

   localparam int N_SAMPLES = 16;
   localparam int N_RESULTS = 18;

   localparam logic [13:0] FFT_WR_ADDR = 14'h0A0;

   // Word 8 is fetched from 0x09A; 0x090 is never addressed.
   localparam logic [13:0] FFT_RD_ADDR [N_RESULTS] = '{
      14'h088, 14'h089, 14'h08A, 14'h08B, 14'h08C, 14'h08D,
      14'h08E, 14'h08F, 14'h09A, 14'h091, 14'h092, 14'h093,
      14'h094, 14'h095, 14'h096, 14'h097, 14'h098, 14'h099
   };

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SETTLE,
      ST_READ,
      ST_DONE
   } fsm_state_t;

endpackage

// File: rtl/fft_sample_buf.sv
// rtl/fft_sample_buf.sv - 16-entry sample LIFO used to reverse a frame (FFT_LOADER_REORDER_EN only)
`ifdef FFT_LOADER_REORDER_EN
module fft_sample_buf
   import fft_bus_pkg::*;
(
   input  logic        mclk,
   input  logic        puc_rst_n,
   input  logic        push,
   input  logic [15:0] push_data,
   input  logic        pop,
   output logic [15:0] top_data
);

   logic [15:0] mem [N_SAMPLES];
   logic [4:0]  depth;
   logic [3:0]  top_idx;

   assign top_idx  = 4'(depth - 5'd1);
   assign top_data = mem[top_idx];

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         depth <= '0;
      end else if (push && !pop) begin
         depth <= depth + 5'd1;
      end else if (pop && !push) begin
         depth <= depth - 5'd1;
      end
   end

   always_ff @(posedge mclk) begin
      if (push) begin
         mem[depth[3:0]] <= push_data;
      end
   end

endmodule
`endif

// File: rtl/fft_bus_loader.sv
// rtl/fft_bus_loader.sv - streams 16 samples into the FFT peripheral and 18 result words back out
// Optional macro FFT_LOADER_REORDER_EN: buffer the frame and write it in reverse arrival order.
module fft_bus_loader
   import fft_bus_pkg::*;
#(
   parameter int SETTLE_CYC = 1
) (
   input  logic        mclk,
   input  logic        puc_rst_n,
   input  logic        start,
   output logic        busy,
   output logic        done,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [15:0] s_data,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [15:0] m_data,
   output logic        m_last,
   output logic [13:0] per_addr,
   output logic [15:0] per_din,
   output logic        per_en,
   output logic [1:0]  per_we,
   input  logic [15:0] per_dout
);

   fsm_state_t  state, state_nxt;
   logic [3:0]  smp_cnt;
   logic [3:0]  set_cnt;
   logic [4:0]  rd_cnt;
   logic [4:0]  rd_idx;
   logic        frame_go, s_fire, wr_en, rd_fire, m_fire, load_last;
   logic [15:0] wr_data;

   assign frame_go = (state == ST_IDLE) && start;
   assign s_fire   = s_valid && s_ready;
   assign m_fire   = m_valid && m_ready;

`ifdef FFT_LOADER_REORDER_EN
   logic        wr_phase;
   logic [15:0] buf_top;

   assign s_ready = (state == ST_LOAD) && !wr_phase;
   assign wr_en   = (state == ST_LOAD) && wr_phase;
   assign wr_data = buf_top;

   fft_sample_buf u_sample_buf (
      .mclk      (mclk),
      .puc_rst_n (puc_rst_n),
      .push      (s_fire),
      .push_data (s_data),
      .pop       (wr_en),
      .top_data  (buf_top)
   );

   // smp_cnt wraps to 0 on the 16th fill, so it counts the write phase afresh
   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         wr_phase <= 1'b0;
      end else if (frame_go || load_last) begin
         wr_phase <= 1'b0;
      end else if (s_fire && (smp_cnt == 4'(N_SAMPLES - 1))) begin
         wr_phase <= 1'b1;
      end
   end
`else
   assign s_ready = (state == ST_LOAD);
   assign wr_en   = s_fire;
   assign wr_data = s_data;
`endif

   assign load_last = wr_en && (smp_cnt == 4'(N_SAMPLES - 1));
   assign rd_fire   = (state == ST_READ) && (rd_cnt != 5'(N_RESULTS)) && (!m_valid || m_ready);
   assign rd_idx    = (rd_cnt < 5'(N_RESULTS)) ? rd_cnt : 5'd0;

   always_ff @(posedge mclk or negedge puc_rst_n) begin
      if (!puc_rst_n) begin
         state   <= ST_IDLE;
         smp_cnt <= '0;
         set_cnt <= '0;
         rd_cnt  <= '0;
         m_valid <= 1'b0;
         m_data  <= '0;
         m_last  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (frame_go) begin
            smp_cnt <= '0;
            set_cnt <= '0;
            rd_cnt  <= '0;
         end else begin
            if (s_fire || wr_en) smp_cnt <= smp_cnt + 4'd1;
            if (state == ST_SETTLE) set_cnt <= set_cnt + 4'd1;
            if (rd_fire) rd_cnt <= rd_cnt + 5'd1;
         end
         // output register: capture on read, release on handshake, hold otherwise
         if (rd_fire) begin
            m_valid <= 1'b1;
            m_data  <= per_dout;
            m_last  <= (rd_cnt == 5'(N_RESULTS - 1));
         end else if (m_fire) begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (start) state_nxt = ST_LOAD;
         ST_LOAD:   if (load_last) state_nxt = ST_SETTLE;
         ST_SETTLE: if (set_cnt == 4'(SETTLE_CYC - 1)) state_nxt = ST_READ;
         ST_READ:   if (m_fire && m_last) state_nxt = ST_DONE;
         ST_DONE:   state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      per_en   = 1'b0;
      per_we   = 2'b00;
      per_addr = '0;
      per_din  = '0;
      if (wr_en) begin
         per_en   = 1'b1;
         per_we   = 2'b11;
         per_addr = FFT_WR_ADDR;
         per_din  = wr_data;
      end else if (rd_fire) begin
         per_en   = 1'b1;
         per_addr = FFT_RD_ADDR[rd_idx];
      end
   end

   assign busy = (state != ST_IDLE);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_fft_bus_loader.sv
// tb/tb_fft_bus_loader.sv - randomized frame bench with an FFT peripheral model and bus/stream monitor
module tb_fft_bus_loader;

   typedef logic [15:0] smp_arr_t [16];

   localparam logic [13:0] RD_TABLE [18] = '{
      14'h088, 14'h089, 14'h08A, 14'h08B, 14'h08C, 14'h08D,
      14'h08E, 14'h08F, 14'h09A, 14'h091, 14'h092, 14'h093,
      14'h094, 14'h095, 14'h096, 14'h097, 14'h098, 14'h099
   };
   localparam int SETTLE = 1;
`ifdef FFT_LOADER_REORDER_EN
   localparam int EXTRA = 16;
`else
   localparam int EXTRA = 0;
`endif
   localparam real PI = 3.14159265358979;

   logic        mclk = 1'b0;
   logic        puc_rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [15:0] s_data = 16'h0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [15:0] m_data;
   logic        m_last;
   logic [13:0] per_addr;
   logic [15:0] per_din;
   logic        per_en;
   logic [1:0]  per_we;
   logic [15:0] per_dout;

   int checks = 0;
   int failures = 0;

   fft_bus_loader #(.SETTLE_CYC(SETTLE)) dut (
      .mclk(mclk), .puc_rst_n(puc_rst_n), .start(start), .busy(busy), .done(done),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .per_addr(per_addr), .per_din(per_din), .per_en(per_en), .per_we(per_we),
      .per_dout(per_dout)
   );

   always #5 mclk = ~mclk;

   // 16-point DFT scaled by 1/16; even words are real parts, odd words imaginary
   function automatic logic [15:0] dft_word(input smp_arr_t a, input int w);
      real acc;
      int  k;
      acc = 0.0;
      k = w / 2;
      for (int n = 0; n < 16; n++) begin
         real x;
         x = $itor($signed(a[n]));
         if (w % 2 == 0) acc = acc + x * $cos(2.0 * PI * k * n / 16.0);
         else            acc = acc - x * $sin(2.0 * PI * k * n / 16.0);
      end
      acc = acc / 16.0;
      return 16'($rtoi(acc >= 0.0 ? acc + 0.5 : acc - 0.5));
   endfunction

   function automatic logic [15:0] periph_read(input logic [13:0] a, input smp_arr_t f);
      for (int w = 0; w < 18; w++) begin
         if (RD_TABLE[w] == a) return dft_word(f, w);
      end
      return 16'hDEAD;
   endfunction

   // where each accepted sample should sit in the peripheral's a0..a15 after a frame
   function automatic smp_arr_t load_order(input smp_arr_t s);
      smp_arr_t a;
      for (int j = 0; j < 16; j++) begin
`ifdef FFT_LOADER_REORDER_EN
         a[j] = s[j];
`else
         a[15 - j] = s[j];
`endif
      end
      return a;
   endfunction

   // FFT peripheral model: shift register on write to 0x0A0, combinational result reads
   smp_arr_t fa = '{default: 16'h0};
   always @(posedge mclk) begin
      if (per_en && per_we == 2'b11 && per_addr == 14'h0A0) begin
         for (int i = 15; i > 0; i--) fa[i] <= fa[i - 1];
         fa[0] <= per_din;
      end
   end
   always_comb per_dout = periph_read(per_addr, fa);

   // monitor
   int          cyc = 0;
   logic [15:0] wr_din_q [$];
   logic [13:0] wr_addr_q [$];
   int          wr_cyc_q [$];
   logic [13:0] rd_addr_q [$];
   int          rd_cyc_q [$];
   logic [15:0] out_data_q [$];
   logic        out_last_q [$];
   int          done_cyc_q [$];
   int          acc_cnt = 0, wr_nofire = 0, rd_blocked = 0, bad_we = 0, idle_bad = 0;
   int          hold_bad = 0, stall_cyc = 0;
   logic        fire_seen = 1'b0, prev_stall = 1'b0, prev_last = 1'b0;
   logic [15:0] prev_data = 16'h0;

   always @(posedge mclk) cyc <= cyc + 1;

   always @(negedge mclk) begin
      fire_seen <= s_valid && s_ready;
      if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;
      if (per_en && per_we == 2'b11) begin
         wr_din_q.push_back(per_din);
         wr_addr_q.push_back(per_addr);
         wr_cyc_q.push_back(cyc);
         if (!(s_valid && s_ready)) wr_nofire <= wr_nofire + 1;
      end
      if (per_en && per_we == 2'b00) begin
         rd_addr_q.push_back(per_addr);
         rd_cyc_q.push_back(cyc);
         if (m_valid && !m_ready) rd_blocked <= rd_blocked + 1;
      end
      if (per_en && per_we != 2'b11 && per_we != 2'b00) bad_we <= bad_we + 1;
      if (!per_en && (per_addr != 14'h0 || per_din != 16'h0 || per_we != 2'b00)) idle_bad <= idle_bad + 1;
      if (m_valid && m_ready) begin
         out_data_q.push_back(m_data);
         out_last_q.push_back(m_last);
      end
      if (done) done_cyc_q.push_back(cyc);
      if (prev_stall) begin
         stall_cyc <= stall_cyc + 1;
         if (!m_valid || m_data !== prev_data || m_last !== prev_last) hold_bad <= hold_bad + 1;
      end
      prev_stall <= m_valid && !m_ready;
      prev_data  <= m_data;
      prev_last  <= m_last;
   end

   // stimulus state, driven only from the main initial block
   logic [15:0] src_q [$];
   bit src_en = 0, src_toggle = 0, tog = 0, stalled = 0, start_in_read = 0, start_pulsed = 0;
   int stall_after = -1, stall_rem = 0;
   int wr_b, rd_b, out_b, done_b, nofire_b, blk_b, hold_b, stall_b, idle_b, badwe_b;

   task automatic tick();
      @(posedge mclk);
      #1;
      if (fire_seen && src_q.size() > 0) void'(src_q.pop_front());
      tog = !tog;
      s_valid = src_en && (src_q.size() > 0) && (!src_toggle || tog);
      s_data  = (src_q.size() > 0) ? src_q[0] : 16'h0;
      if (stall_after >= 0 && !stalled && (out_data_q.size() - out_b) >= stall_after) begin
         stall_rem = 5;
         stalled = 1;
      end
      if (stall_rem > 0) begin
         m_ready = 1'b0;
         stall_rem--;
      end else begin
         m_ready = 1'b1;
      end
      start = 1'b0;
      if (start_in_read && !start_pulsed && (rd_addr_q.size() - rd_b) == 3) begin
         start = 1'b1;
         start_pulsed = 1;
      end
   endtask

   task automatic snap_bases();
      wr_b = wr_din_q.size();     rd_b = rd_addr_q.size();    out_b = out_data_q.size();
      done_b = done_cyc_q.size(); nofire_b = wr_nofire;       blk_b = rd_blocked;
      hold_b = hold_bad;          stall_b = stall_cyc;        idle_b = idle_bad;
      badwe_b = bad_we;
   endtask

   task automatic run_frame(input smp_arr_t smp, input bit toggle, input int stall_aft,
                            input bit start_rd, output int t0);
      int n;
      src_q = {};
      for (int i = 0; i < 16; i++) src_q.push_back(smp[i]);
      src_en = 1; src_toggle = toggle; stall_after = stall_aft; stalled = 0;
      start_in_read = start_rd; start_pulsed = 0;
      snap_bases();
      t0 = cyc;
      start = 1'b1;
      tick();
      n = 0;
      while (done_cyc_q.size() == done_b && n < 400) begin
         tick();
         n++;
      end
      checks++;
      if (done_cyc_q.size() == done_b) begin
         failures++;
         $display("FAIL frame_timeout: no done after %0d cycles", n);
      end
      tick();
      tick();
      src_en = 0; start_in_read = 0; stall_after = -1;
   endtask

   task automatic check_results(input string tag, input smp_arr_t smp);
      smp_arr_t arr;
      logic [15:0] exp_w;
      arr = load_order(smp);
      checks++;
      if (out_data_q.size() - out_b != 18) begin
         failures++;
         $display("FAIL %s_out_count: got %0d want 18", tag, out_data_q.size() - out_b);
      end
      for (int i = 0; i < 18 && out_b + i < out_data_q.size(); i++) begin
         exp_w = dft_word(arr, i);
         checks++;
         if (out_data_q[out_b + i] !== exp_w || out_last_q[out_b + i] !== (i == 17)) begin
            failures++;
            $display("FAIL %s_word[%0d]: got %h last=%0b want %h last=%0b", tag, i,
                     out_data_q[out_b + i], out_last_q[out_b + i], exp_w, (i == 17));
         end
      end
      checks++;
      if (rd_addr_q.size() - rd_b != 18) begin
         failures++;
         $display("FAIL %s_rd_count: got %0d want 18", tag, rd_addr_q.size() - rd_b);
      end
      for (int i = 0; i < 18 && rd_b + i < rd_addr_q.size(); i++) begin
         checks++;
         if (rd_addr_q[rd_b + i] !== RD_TABLE[i]) begin
            failures++;
            $display("FAIL %s_rd_addr[%0d]: got %h want %h", tag, i, rd_addr_q[rd_b + i], RD_TABLE[i]);
         end
      end
      checks++;
      if (idle_bad != idle_b || bad_we != badwe_b) begin
         failures++;
         $display("FAIL %s_bus_idle: idle_bad=%0d bad_we=%0d want 0", tag, idle_bad - idle_b, bad_we - badwe_b);
      end
   endtask

   task automatic test_reset();
      int wr0, rd0, d0;
      repeat (3) tick();
      checks++;
      if ({busy, done, s_ready, m_valid, m_last, per_en} !== 6'b0) begin
         failures++;
         $display("FAIL reset_flags: got %b want 000000", {busy, done, s_ready, m_valid, m_last, per_en});
      end
      checks++;
      if (m_data !== 16'h0) begin failures++; $display("FAIL reset_m_data: got %h want 0000", m_data); end
      checks++;
      if (per_addr !== 14'h0 || per_din !== 16'h0 || per_we !== 2'b00) begin
         failures++;
         $display("FAIL reset_bus: got addr=%h din=%h we=%b want 0", per_addr, per_din, per_we);
      end
      puc_rst_n = 1'b1;
      tick();
      checks++;
      if (busy !== 1'b0 || s_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: got busy=%0b s_ready=%0b want 0 0", busy, s_ready);
      end
      // abort a frame after 7 accepted samples
      src_q = {};
      for (int i = 0; i < 16; i++) src_q.push_back(16'($urandom));
      src_en = 1; src_toggle = 0;
      snap_bases();
      begin
         int a0, n;
         a0 = acc_cnt;
         start = 1'b1;
         tick();
         n = 0;
         while (acc_cnt - a0 < 7 && n < 50) begin tick(); n++; end
         checks++;
         if (acc_cnt - a0 != 7) begin
            failures++;
            $display("FAIL reset_accepts: got %0d want 7", acc_cnt - a0);
         end
      end
      puc_rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, s_ready, m_valid, m_last, per_en} !== 6'b0 || m_data !== 16'h0 ||
          per_addr !== 14'h0 || per_din !== 16'h0 || per_we !== 2'b00) begin
         failures++;
         $display("FAIL midload_reset_outputs: got flags=%b m_data=%h addr=%h din=%h we=%b want all 0",
                  {busy, done, s_ready, m_valid, m_last, per_en}, m_data, per_addr, per_din, per_we);
      end
      wr0 = wr_din_q.size(); rd0 = rd_addr_q.size(); d0 = done_cyc_q.size();
      checks++;
      if (wr0 - wr_b != 7 - EXTRA / 16 * 7) begin
         failures++;
         $display("FAIL midload_writes: got %0d want %0d", wr0 - wr_b, 7 - EXTRA / 16 * 7);
      end
      src_en = 0;
      tick(); tick();
      puc_rst_n = 1'b1;
      repeat (40) tick();
      checks++;
      if (wr_din_q.size() != wr0 || rd_addr_q.size() != rd0 || done_cyc_q.size() != d0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL after_abort_quiet: got wr+%0d rd+%0d done+%0d busy=%0b want 0 0 0 0",
                  wr_din_q.size() - wr0, rd_addr_q.size() - rd0, done_cyc_q.size() - d0, busy);
      end
   endtask

   task automatic test_basic();
      smp_arr_t smp;
      int t0, rd0;
      logic [15:0] exp_din;
      for (int i = 0; i < 16; i++) smp[i] = 16'(i + 1);
      run_frame(smp, 0, -1, 0, t0);
      checks++;
      if (wr_din_q.size() - wr_b != 16) begin
         failures++;
         $display("FAIL basic_wr_count: got %0d want 16", wr_din_q.size() - wr_b);
      end
      for (int i = 0; i < 16 && wr_b + i < wr_din_q.size(); i++) begin
`ifdef FFT_LOADER_REORDER_EN
         exp_din = 16'(16 - i);
`else
         exp_din = 16'(i + 1);
`endif
         checks++;
         if (wr_din_q[wr_b + i] !== exp_din || wr_addr_q[wr_b + i] !== 14'h0A0 ||
             wr_cyc_q[wr_b + i] != t0 + 1 + EXTRA + i) begin
            failures++;
            $display("FAIL basic_wr[%0d]: got din=%h addr=%h cyc=%0d want din=%h addr=0a0 cyc=%0d", i,
                     wr_din_q[wr_b + i], wr_addr_q[wr_b + i], wr_cyc_q[wr_b + i] - t0, exp_din, 1 + EXTRA + i);
         end
      end
      rd0 = t0 + 17 + SETTLE + EXTRA;
      for (int i = 0; i < 18 && rd_b + i < rd_cyc_q.size(); i++) begin
         checks++;
         if (rd_cyc_q[rd_b + i] != rd0 + i || rd_addr_q[rd_b + i] == 14'h090) begin
            failures++;
            $display("FAIL basic_rd_timing[%0d]: got cyc=%0d addr=%h want cyc=%0d", i,
                     rd_cyc_q[rd_b + i] - t0, rd_addr_q[rd_b + i], rd0 + i - t0);
         end
      end
      checks++;
      if (done_cyc_q.size() - done_b != 1 || done_cyc_q[done_b] != rd0 + 17 + 2) begin
         failures++;
         $display("FAIL basic_done: got count=%0d cyc=%0d want count=1 cyc=%0d", done_cyc_q.size() - done_b,
                  done_cyc_q[done_b] - t0, rd0 + 19 - t0);
      end
      check_results("basic", smp);
   endtask

   task automatic test_patterns();
      smp_arr_t smp;
      int t0;
      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 16; i++) smp[i] = (p == 0) ? 16'h0000 : 16'h0100;
         run_frame(smp, 0, -1, 0, t0);
         checks++;
         if (out_data_q.size() - out_b != 18) begin
            failures++;
            $display("FAIL pattern%0d_count: got %0d want 18", p, out_data_q.size() - out_b);
         end
         for (int i = 0; i < 18 && out_b + i < out_data_q.size(); i++) begin
            logic [15:0] exp_w;
            exp_w = (p == 1 && i == 0) ? 16'h0100 : 16'h0000;
            checks++;
            if (out_data_q[out_b + i] !== exp_w) begin
               failures++;
               $display("FAIL pattern%0d_word[%0d]: got %h want %h", p, i, out_data_q[out_b + i], exp_w);
            end
         end
      end
   endtask

   task automatic test_stall();
      smp_arr_t smp;
      int t0;
      for (int i = 0; i < 16; i++) smp[i] = 16'($urandom);
      run_frame(smp, 1, 5, 0, t0);
      checks++;
      if (wr_din_q.size() - wr_b != 16) begin
         failures++;
         $display("FAIL stall_wr_count: got %0d want 16", wr_din_q.size() - wr_b);
      end
`ifndef FFT_LOADER_REORDER_EN
      checks++;
      if (wr_nofire != nofire_b) begin
         failures++;
         $display("FAIL stall_wr_unaccepted: got %0d want 0", wr_nofire - nofire_b);
      end
`endif
      checks++;
      if (stall_cyc - stall_b < 5 || hold_bad != hold_b) begin
         failures++;
         $display("FAIL stall_hold: got stall_cycles=%0d changes=%0d want >=5 and 0",
                  stall_cyc - stall_b, hold_bad - hold_b);
      end
      checks++;
      if (rd_blocked != blk_b) begin
         failures++;
         $display("FAIL stall_read_while_full: got %0d want 0", rd_blocked - blk_b);
      end
      check_results("stall", smp);
   endtask

   task automatic test_back_to_back();
      smp_arr_t smp;
      int t0;
      int tr [2][$];
      for (int i = 0; i < 16; i++) smp[i] = 16'($urandom);
      for (int f = 0; f < 2; f++) begin
         run_frame(smp, 0, -1, (f == 0), t0);
         checks++;
         if (done_cyc_q.size() - done_b != 1) begin
            failures++;
            $display("FAIL frame%0d_done_count: got %0d want 1", f, done_cyc_q.size() - done_b);
         end
         check_results(f == 0 ? "restart_f0" : "restart_f1", smp);
         for (int i = wr_b; i < wr_din_q.size(); i++) begin
            tr[f].push_back(int'(wr_din_q[i]));
            tr[f].push_back(wr_cyc_q[i] - t0);
         end
         for (int i = rd_b; i < rd_addr_q.size(); i++) begin
            tr[f].push_back(int'(rd_addr_q[i]));
            tr[f].push_back(rd_cyc_q[i] - t0);
         end
         for (int i = done_b; i < done_cyc_q.size(); i++) tr[f].push_back(done_cyc_q[i] - t0);
      end
      checks++;
      if (tr[0].size() != tr[1].size()) begin
         failures++;
         $display("FAIL restart_trace_len: got %0d want %0d", tr[1].size(), tr[0].size());
      end
      for (int i = 0; i < tr[0].size() && i < tr[1].size(); i++) begin
         checks++;
         if (tr[1][i] != tr[0][i]) begin
            failures++;
            $display("FAIL restart_trace[%0d]: got %0d want %0d", i, tr[1][i], tr[0][i]);
         end
      end
      checks++;
      if (tr[0].size() > 36 && tr[0][33] != 17 + SETTLE + EXTRA) begin
         failures++;
         $display("FAIL restart_first_read: got cycle %0d want %0d", tr[0][33], 17 + SETTLE + EXTRA);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_patterns();
      test_stall();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fft_bus_loader.md
# fft_bus_loader

Bus initiator that drives the 16-point FFT peripheral from the other end of the openMSP430-style peripheral bus. It accepts 16 time-domain samples on a valid/ready stream, writes them into the FFT's sample shift register, waits for the combinational FFT to settle, then reads the 18 result words back and emits them on an output stream. It sits between a sample source (ADC front end or DMA) and the FFT peripheral, so the CPU does not have to spend bus cycles loading and unloading it.

## Interface
- N_SAMPLES, 16, samples written per frame (fixed by FFT peripheral)
- N_RESULTS, 18, result words read per frame (dre/dim pairs for bins 0..8)
- SETTLE_CYC, 1, idle cycles between last write and first read (1..15)

- mclk  in  1  system clock, all logic rising-edge
- puc_rst_n  in  1  asynchronous active-low reset
- start  in  1  begin one frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the frame completes
- s_valid  in  1  sample available
- s_ready  out  1  block accepts sample
- s_data  in  16  sample, two's complement
- m_valid  out  1  result word available
- m_ready  in  1  sink accepts result word
- m_data  out  16  result word
- m_last  out  1  high with the 18th result word (dim[8])
- per_addr  out  14  peripheral word address
- per_din  out  16  peripheral write data
- per_en  out  1  bus cycle enable
- per_we  out  2  byte write enables
- per_dout  in  16  peripheral read data (combinational, same cycle)

## Operation
- FSM states: IDLE, LOAD, SETTLE, READ, DONE.
- IDLE: start=1 moves to LOAD and clears the counters. start in any other state is ignored.
- LOAD: s_ready=1. On each s_valid&s_ready: per_en=1, per_we=2'b11, per_addr=0x0A0, per_din=s_data, sample counter +1. After the 16th accept, go to SETTLE. When the stream stalls, per_en=0.
- Shift order: the first sample accepted ends up in a15 and the last in a0.
- SETTLE: bus idle, counts SETTLE_CYC cycles, then goes to READ.
- READ: a read is issued only when the output register is free (!m_valid || m_ready). The read drives per_en=1, per_we=2'b00 and per_addr from the read table, and captures per_dout into m_data in the same cycle. Result counter +1.
- Read table, index 0..17: 0x088, 0x089, 0x08A, 0x08B, 0x08C, 0x08D, 0x08E, 0x08F, 0x09A, 0x091, 0x092, 0x093, 0x094, 0x095, 0x096, 0x097, 0x098, 0x099. Address 0x090 is never issued.
- After the 18th word is handshaken on m_*, go to DONE. DONE lasts one cycle with done=1, then returns to IDLE.
- per_addr and per_din are 0 whenever per_en=0.

## Timing
- Reset values: busy=0, done=0, s_ready=0, m_valid=0, m_data=0, m_last=0, per_en=0, per_we=0, per_addr=0, per_din=0. The FSM resets to IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial output is flushed. The FFT keeps whatever samples were already shifted in.
- start at cycle 0 puts the block in LOAD at cycle 1. With back-to-back samples, the writes occur at cycles 1..16.
- The first read occurs at cycle 17+SETTLE_CYC, and m_valid rises the cycle after.
- With m_ready held high, results stream one word per cycle. done pulses 2 cycles after the last read cycle.
- m_data, m_valid and m_last are held stable while m_valid&!m_ready.

## Configuration
- FFT_LOADER_REORDER_EN defined: add a 16x16 sample buffer. LOAD first fills the buffer (no bus writes), then issues 16 back-to-back writes in reverse arrival order, so sample 0 lands in a0. This adds 16 cycles before SETTLE. s_ready=0 during the write phase.
- Undefined: direct pass-through as described above, with no buffer.

## Structure
- Package fft_bus_pkg holds:
  - the FSM state encoding
  - FFT_WR_ADDR=14'h0A0
  - the 18-entry FFT_RD_ADDR table
  - N_SAMPLES and N_RESULTS
- Sub-module fft_sample_buf (16-entry LIFO) exists only under FFT_LOADER_REORDER_EN.

## Test plan
- Reset mid-LOAD after 7 samples -> all outputs at reset values, FSM in IDLE, no further per_en.
- 16 back-to-back samples 0x0001..0x0010, m_ready=1:
  - 16 writes to 0x0A0 with per_we=2'b11 at cycles 1..16.
  - 18 reads in table order, never touching 0x090.
  - m_last only on word 18; done exactly once.
- Full frame against an FFT peripheral model:
  - all-zero input -> 18 words of 0x0000.
  - all-0x0100 input -> word 0 (dre[0]) equals the model's DC value, every other word 0x0000.
- s_valid toggled every other cycle and m_ready held low for 5 cycles mid-READ:
  - per_en only on accepted samples.
  - m_data held stable during the stall.
  - no reads issued while the output register is full.
- start pulsed again during READ -> ignored. A start after done -> a second frame with identical bus trace.
- FFT_LOADER_REORDER_EN defined, samples 0x0001..0x0010 -> per_din sequence 0x0010 down to 0x0001. The first read occurs 16 cycles later than without the macro.
